// File: rtl/addsub_sliced_unit_if.sv
// ---------------------------------------------------------------------------
// addsub_sliced_unit_if
// Request/result bundle between the UART command decoder (master) and the
// sliced add/subtract unit (slave).
//   i_data_rdy : operand-valid level; the unit acts on its rising edge only
//   i_sub      : 1 = i_r1 - i_r2, 0 = i_r1 + i_r2 + i_cin
//   i_r1/i_r2  : operands A / B
//   i_cin      : carry in, add mode only
//   o_sum      : registered result
//   o_cout     : carry out (sub mode: 1 = no borrow)
//   o_ovf      : two's-complement overflow
//   o_busy     : calculation in progress
//   o_rdy      : result-valid pulse
// ---------------------------------------------------------------------------
interface addsub_sliced_unit_if #(
  parameter int WIDTH = 16
);
  logic             i_data_rdy;
  logic             i_sub;
  logic [WIDTH-1:0] i_r1;
  logic [WIDTH-1:0] i_r2;
  logic             i_cin;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_busy;
  logic             o_rdy;

  modport master (
    output i_data_rdy, i_sub, i_r1, i_r2, i_cin,
    input  o_sum, o_cout, o_ovf, o_busy, o_rdy
  );

  modport slave (
    input  i_data_rdy, i_sub, i_r1, i_r2, i_cin,
    output o_sum, o_cout, o_ovf, o_busy, o_rdy
  );
endinterface

// File: rtl/addsub_sliced_unit.sv
// ---------------------------------------------------------------------------
// addsub_sliced_unit
// Parametrised add/subtract unit. Operands are captured on a rising edge of
// bus.i_data_rdy and summed SLICE bits per clock through one SLICE-bit adder.
// The final slice registers sum, carry and overflow and fires an o_rdy pulse
// RDY_PULSE cycles long. A UART-controlled mux drives the debug LEDs.
//
// Ports:
//   i_clk_in      : system clock
//   i_rst         : asynchronous active-high reset
//   bus           : addsub_sliced_unit_if.slave (operands, results, flags)
//   i_ctrl_signal : i_ctrl holds a valid debug control char
//   i_ctrl        : debug control char
//   o_debug_led   : debug display register
//
// Optional build macro ADDSUB_DROP_CNT_EN: adds an 8-bit saturating count of
// requests that arrived while busy (shown on debug char 0x7C, cleared by 0x7F).
// ---------------------------------------------------------------------------
module addsub_sliced_unit #(
  parameter int WIDTH     = 16,
  parameter int SLICE     = 4,
  parameter int RDY_PULSE = 2
) (
  input  logic                     i_clk_in,
  input  logic                     i_rst,
  addsub_sliced_unit_if.slave      bus,
  input  logic                     i_ctrl_signal,
  input  logic [7:0]               i_ctrl,
  output logic [7:0]               o_debug_led
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t            state_reg;
  logic [1:0]        tap_reg;
  logic [KW-1:0]     k_reg;
  logic [WIDTH-1:0]  x_reg;
  logic [WIDTH-1:0]  y_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  sum_out_reg;
  logic              cout_reg;
  logic              ovf_reg;
  logic              busy_reg;
  logic              rdy_reg;
  logic [3:0]        pulse_cnt_reg;
  logic [7:0]        led_reg;

  logic              go;
  logic              last_slice;
  logic [SLICE-1:0]  x_slice [NSLICE];
  logic [SLICE-1:0]  y_slice [NSLICE];
  logic [SLICE-1:0]  x_cur;
  logic [SLICE-1:0]  y_cur;
  logic [SLICE:0]    slice_res;
  logic [WIDTH-1:0]  sum_next;
  logic              ovf_next;
  logic [3:0]        k_dbg;

  // Only the rising edge of the UART strobe starts a request.
  assign go         = tap_reg[0] & ~tap_reg[1];
  assign last_slice = (k_reg == KW'(NSLICE - 1));

  // Split operands into slices; the sum slot selected by k takes the fresh
  // slice result, all others keep their already-computed value.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign x_slice[gi] = x_reg[gi*SLICE +: SLICE];
      assign y_slice[gi] = y_reg[gi*SLICE +: SLICE];
      assign sum_next[gi*SLICE +: SLICE] =
        (k_reg == KW'(gi)) ? slice_res[SLICE-1:0] : sum_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign x_cur     = x_slice[k_reg];
  assign y_cur     = y_slice[k_reg];
  assign slice_res = {1'b0, x_cur} + {1'b0, y_cur} + {{SLICE{1'b0}}, carry_reg};

  // y already holds ~B in sub mode, so one formula covers both operations.
  assign ovf_next = (x_reg[WIDTH-1] == y_reg[WIDTH-1]) &&
                    (sum_next[WIDTH-1] != x_reg[WIDTH-1]);

  assign k_dbg = 4'(k_reg);

  // Control FSM, datapath and result registers.
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      tap_reg       <= '0;
      k_reg         <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      sum_out_reg   <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      rdy_reg       <= 1'b0;
      pulse_cnt_reg <= '0;
    end else begin
      tap_reg <= {tap_reg[0], bus.i_data_rdy};

      if (pulse_cnt_reg != 4'd0) begin
        pulse_cnt_reg <= pulse_cnt_reg - 4'd1;
        if (pulse_cnt_reg == 4'd1) begin
          rdy_reg <= 1'b0;
        end
      end

      case (state_reg)
        IDLE: begin
          if (go) begin
            x_reg     <= bus.i_r1;
            y_reg     <= bus.i_sub ? ~bus.i_r2 : bus.i_r2;
            carry_reg <= bus.i_sub ? 1'b1 : bus.i_cin;
            k_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_res[SLICE];
          k_reg     <= k_reg + KW'(1);
          if (last_slice) begin
            sum_out_reg   <= sum_next;
            cout_reg      <= slice_res[SLICE];
            ovf_reg       <= ovf_next;
            busy_reg      <= 1'b0;
            // Overrides the countdown above, so back-to-back results keep
            // o_rdy high continuously.
            rdy_reg       <= 1'b1;
            pulse_cnt_reg <= 4'(RDY_PULSE);
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ADDSUB_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      drop_cnt_reg <= '0;
    end else if (i_ctrl_signal && (i_ctrl == 8'h7F)) begin
      drop_cnt_reg <= '0;
    end else if (go && (state_reg == CALC) && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end
`endif

  // Debug LED mux; unknown control chars leave the display unchanged.
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      led_reg <= '0;
    end else if (!i_ctrl_signal) begin
      led_reg <= sum_out_reg[7:0];
    end else begin
      case (i_ctrl)
        8'h0D: led_reg <= sum_out_reg[7:0];
        8'h7A: led_reg <= {cout_reg, ovf_reg, busy_reg, state_reg, k_dbg};
        8'h7B: led_reg <= x_reg[7:0];
        8'h7D: led_reg <= y_reg[7:0];
`ifdef ADDSUB_DROP_CNT_EN
        8'h7C: led_reg <= drop_cnt_reg;
`else
        8'h7C: led_reg <= bus.i_r1[7:0];
`endif
        8'h7E: led_reg <= bus.i_r2[7:0];
        8'h7F: led_reg <= 8'h00;
        default: led_reg <= led_reg;
      endcase
    end
  end

  assign bus.o_sum   = sum_out_reg;
  assign bus.o_cout  = cout_reg;
  assign bus.o_ovf   = ovf_reg;
  assign bus.o_busy  = busy_reg;
  assign bus.o_rdy   = rdy_reg;
  assign o_debug_led = led_reg;

endmodule

// File: tb/tb_addsub_sliced_unit.sv
// ---------------------------------------------------------------------------
// tb_addsub_sliced_unit
// Directed checks of addsub_sliced_unit at default parameters: add/sub
// results and flags, latency and pulse width, dropped requests, async reset
// mid-calculation and the debug LED mux.
// ---------------------------------------------------------------------------
module tb_addsub_sliced_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctrl_signal = 1'b0;
  logic [7:0] ctrl = 8'h00;
  logic [7:0] led;

  int checks = 0;
  int passed = 0;

  addsub_sliced_unit_if #(.WIDTH(16)) bus ();

  addsub_sliced_unit #(
    .WIDTH(16), .SLICE(4), .RDY_PULSE(2)
  ) dut (
    .i_clk_in      (clk),
    .i_rst         (rst),
    .bus           (bus.slave),
    .i_ctrl_signal (ctrl_signal),
    .i_ctrl        (ctrl),
    .o_debug_led   (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge. Raises i_data_rdy and checks latency, busy length,
  // pulse width and the registered result.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin, input logic [15:0] exp_sum,
                       input logic exp_c, input logic exp_v);
    int n;
    int busy_n;
    bus.i_r1 = a; bus.i_r2 = b; bus.i_sub = sub; bus.i_cin = cin;
    bus.i_data_rdy = 1'b1;
    n = 0; busy_n = 0;
    while (!bus.o_rdy && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.o_busy) busy_n++;
    end
    check({tag, " latency"}, n, 6);
    check({tag, " busy_cycles"}, busy_n, 4);
    @(negedge clk);
    check({tag, " rdy_2nd"}, bus.o_rdy, 1'b1);
    @(negedge clk);
    check({tag, " rdy_off"}, bus.o_rdy, 1'b0);
    bus.i_data_rdy = 1'b0;
    check({tag, " sum"}, bus.o_sum, exp_sum);
    check({tag, " cout"}, bus.o_cout, exp_c);
    check({tag, " ovf"}, bus.o_ovf, exp_v);
    $display("op %s: a=%04h b=%04h sub=%0d cin=%0d -> sum=%04h c=%0d v=%0d",
             tag, a, b, sub, cin, bus.o_sum, bus.o_cout, bus.o_ovf);
    @(negedge clk);
  endtask

  initial begin
    int rdy_rises;
    int rdy_high;
    logic rdy_prev;

    bus.i_data_rdy = 1'b0; bus.i_sub = 1'b0; bus.i_cin = 1'b0;
    bus.i_r1 = '0; bus.i_r2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst sum", bus.o_sum, 16'h0000);
    check("rst busy", bus.o_busy, 1'b0);
    check("rst rdy", bus.o_rdy, 1'b0);
    check("rst led", led, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    do_op("add",      16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    do_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    do_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_carry",16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    do_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Second request during CALC is dropped
    bus.i_r1 = 16'h1111; bus.i_r2 = 16'h2222; bus.i_sub = 1'b0; bus.i_cin = 1'b0;
    bus.i_data_rdy = 1'b1;
    rdy_rises = 0; rdy_high = 0; rdy_prev = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.i_data_rdy = 1'b0;
        bus.i_r1 = 16'h5555; bus.i_r2 = 16'h5555;
      end
      if (i == 3) bus.i_data_rdy = 1'b1;
      if (bus.o_rdy && !rdy_prev) rdy_rises++;
      if (bus.o_rdy) rdy_high++;
      rdy_prev = bus.o_rdy;
    end
    check("drop rdy_count", rdy_rises, 1);
    check("drop rdy_width", rdy_high, 2);
    check("drop sum", bus.o_sum, 16'h3333);
    $display("op drop: first 1111+2222, second ignored -> sum=%04h rdy_pulses=%0d",
             bus.o_sum, rdy_rises);
    ctrl_signal = 1'b1; ctrl = 8'h7C;
    @(negedge clk);
`ifdef ADDSUB_DROP_CNT_EN
    check("drop counter", led, 8'h01);
`else
    check("dbg r1", led, 8'h55);
`endif
    ctrl_signal = 1'b0;
    bus.i_data_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset in the middle of CALC
    bus.i_r1 = 16'h00FF; bus.i_r2 = 16'h0001;
    bus.i_data_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst busy", bus.o_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst sum", bus.o_sum, 16'h0000);
    check("arst busy", bus.o_busy, 1'b0);
    check("arst rdy", bus.o_rdy, 1'b0);
    check("arst led", led, 8'h00);
    bus.i_data_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rdy_rises = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_rdy) rdy_rises++;
    end
    check("arst no_rdy", rdy_rises, 0);
    $display("op arst: reset mid-calc, rdy seen %0d times afterwards", rdy_rises);
    do_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Debug mux
    ctrl_signal = 1'b1; ctrl = 8'h0D;
    @(negedge clk);
    check("dbg 0D", led, 8'h07);
    ctrl = 8'h7F;
    @(negedge clk);
    check("dbg 7F", led, 8'h00);
    ctrl = 8'h41;
    repeat (2) @(negedge clk);
    check("dbg hold", led, 8'h00);
    ctrl = 8'h7E;
    @(negedge clk);
    check("dbg 7E", led, 8'h04);
    ctrl = 8'h7B;
    @(negedge clk);
    check("dbg 7B", led, 8'h03);
    ctrl_signal = 1'b0; ctrl = 8'h7F;
    @(negedge clk);
    check("dbg off", led, 8'h07);
    $display("op debug: final led=%02h", led);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/addsub_sliced_unit.md
Name: addsub_sliced_unit

Overview:
- Parametrised add/subtract unit that replaces the fixed 4-bit lab adder.
- Operands are latched on a rising edge of `i_data_rdy` (UART-domain strobe). The sum is computed SLICE bits per clock through a single SLICE-bit adder slice.
- Results are registered, with carry/borrow and signed-overflow flags, and announced by a fixed-width `o_rdy` pulse.
- Includes a UART-controlled debug LED mux; sits between the UART command decoder and the result formatter.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE, max 32.
- SLICE, 4, bits added per clock; NSLICE = WIDTH/SLICE.
- RDY_PULSE, 2, `o_rdy` high time in `i_clk_in` cycles (1..15).

Ports:
- i_clk_in  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_data_rdy  in  1  operands valid; level from UART block, only its rising edge is used.
- i_sub  in  1  1 = i_r1 - i_r2, 0 = i_r1 + i_r2 + i_cin.
- i_r1  in  WIDTH  operand A.
- i_r2  in  WIDTH  operand B.
- i_cin  in  1  carry in (add mode only).
- i_ctrl_signal  in  1  i_ctrl holds a valid debug control char.
- i_ctrl  in  8  debug control char.
- o_sum  out  WIDTH  registered result.
- o_cout  out  1  carry out; in sub mode 1 = no borrow.
- o_ovf  out  1  two's-complement overflow.
- o_busy  out  1  calculation in progress.
- o_rdy  out  1  result-valid pulse, RDY_PULSE cycles.
- o_debug_led  out  8  debug display.

Behaviour:
- Reset: asynchronous on `i_rst`. Clears:
  - edge taps, state (IDLE), slice counter, x, y, carry;
  - o_sum, o_cout, o_ovf, o_busy, o_rdy, pulse counter, o_debug_led (all 0).
  - Reset mid-CALC aborts the operation; no `o_rdy` is produced.
- Edge detect:
  - `tap[1:0] <= {tap[0], i_data_rdy}` every clock.
  - `go = tap[0] & ~tap[1]`.
  - Holding `i_data_rdy` high produces exactly one `go`.
- FSM IDLE -> CALC -> IDLE:
  - IDLE, go=1: load x=i_r1 and y = i_sub ? ~i_r2 : i_r2; carry = i_sub ? 1 : i_cin (i_cin ignored in sub). Clear slice index k; o_busy<=1; go to CALC.
  - CALC, each clock: add slice k of x, y and carry; write that slice of the internal sum; update carry; k<=k+1.
  - Final slice (k = NSLICE-1) registers, in the same clock:
    - o_sum = full sum, o_cout = final carry;
    - o_ovf = (x_msb == y_msb) & (sum_msb != x_msb), where y is the inverted operand in sub mode;
    - o_busy<=0, o_rdy<=1, pulse counter loads RDY_PULSE; return to IDLE.
  - go seen in CALC is ignored (dropped). Operands are not re-sampled.
- Latency: go at edge T1 -> o_rdy rises at edge T1+NSLICE (default 4 clocks after load, 5 after first `i_data_rdy` sample).
- o_rdy pulse:
  - high exactly RDY_PULSE cycles, then low;
  - a new result completing while the pulse is active reloads the counter, so o_rdy stays high continuously.
- o_sum, o_cout and o_ovf hold until the next completion or reset. A new request in IDLE during the pulse is accepted.
- Debug LED register, updated each clock:
  - i_ctrl_signal=0: o_sum[7:0].
  - i_ctrl_signal=1, by i_ctrl value:
    - 0x0D: o_sum[7:0]
    - 0x7A: {o_cout, o_ovf, o_busy, state, k[3:0]}
    - 0x7B: x[7:0]
    - 0x7D: y[7:0]
    - 0x7C: i_r1[7:0]
    - 0x7E: i_r2[7:0]
    - 0x7F: 0x00
    - any other char: hold.

Optional Feature:
- Macro: ADDSUB_DROP_CNT_EN.
- When defined:
  - an 8-bit saturating counter increments on every go that arrives during CALC (ignored request);
  - it clears on reset or on debug char 0x7F;
  - debug char 0x7C shows the counter instead of i_r1[7:0].
- When undefined: no counter logic; 0x7C shows i_r1[7:0].

Test Plan:
- Add, default params: 0x1234 + 0x0FCD, cin=0 -> o_sum=0x2201, cout=0, ovf=0; o_busy high 4 cycles; o_rdy high exactly 2 cycles starting 4 clocks after go.
- Sub: 0x0005 - 0x0007, cin=1 (ignored) -> o_sum=0xFFFE, cout=0, ovf=0. Then 0x0007 - 0x0005 -> 0x0002, cout=1.
- Overflow/carry:
  - 0x7FFF + 0x0001 -> 0x8000, ovf=1, cout=0;
  - 0xFFFF + 0x0001, cin=1 -> 0x0001, cout=1, ovf=0;
  - 0x8000 - 0x0001 -> 0x7FFF, ovf=1.
- Busy drop: toggle i_data_rdy again during CALC with new operands -> result from first operands only; single o_rdy; drop counter reads 0x01 via 0x7C when ADDSUB_DROP_CNT_EN is defined.
- Async reset asserted mid-CALC (between clock edges) -> all outputs 0 immediately; no o_rdy; next request 0x0003 + 0x0004 -> 0x0007.
- Debug mux:
  - ctrl_signal=1, 0x0D -> led = o_sum[7:0];
  - 0x7F -> 0x00;
  - 0x41 -> holds previous;
  - ctrl_signal=0 -> o_sum[7:0].
